// File: rtl/counter_pkg.sv
// Shared definitions for the lab counter blocks: FSM state encodings and the
// state-register width.
package counter_pkg;

    localparam int unsigned STATE_W = 2;

    // IDLE: holding, no period loaded. RUN: decrementing on enabled edges.
    // DONE: one-shot period has expired, count parked at zero.
    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage : counter_pkg

// File: rtl/tflipflop.sv
// Single T flip-flop: toggles Q on a rising Clock edge while Enable is high.
// Ports:
//   Clock   - system clock, rising edge
//   Enable  - toggle enable
//   Clear_b - asynchronous active-low clear, forces Q to 0
//   Q       - stored bit
module tflipflop (
    input  logic Clock,
    input  logic Enable,
    input  logic Clear_b,
    output logic Q
);

    // Toggle storage with asynchronous clear.
    always_ff @(posedge Clock or negedge Clear_b) begin
        if (!Clear_b) begin
            Q <= 1'b0;
        end else if (Enable) begin
            Q <= ~Q;
        end
    end

endmodule : tflipflop

// File: rtl/down_counter_reload.sv
// Loadable, enable-gated down counter used as a rate divider. Emits a
// registered one-cycle Tick every N enabled cycles (AutoReload=1) or once
// after N enabled cycles (AutoReload=0, then parks in DONE).
// The count is held in one T flip-flop per bit; every next-count decision is
// expressed as a toggle mask over the current value.
// Ports:
//   Clock        - system clock, rising edge
//   Clear_b      - asynchronous active-low clear of count, reload, Tick, state
//   Enable       - one decrement per edge while high in RUN
//   Load         - synchronous parallel load strobe, priority over Enable
//   LoadValue    - period N captured on Load
//   AutoReload   - 1 periodic / 0 one-shot, sampled at the terminal edge
//   CounterValue - current count
//   Tick         - registered one-cycle terminal-count pulse
//   Busy         - state is RUN
//   Done         - state is DONE
module down_counter_reload
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Clear_b,
    input  logic             Enable,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadValue,
    input  logic             AutoReload,
    output logic [WIDTH-1:0] CounterValue,
    output logic             Tick,
    output logic             Busy,
    output logic             Done
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] toggle;
    logic             tick_q;
    logic             tick_d;
    logic             run_en;
    logic             terminal;

    assign run_en   = (state_q == RUN) && Enable;
    assign terminal = run_en && (count_q == ONE);

    // Next state, Tick and per-bit toggle mask. Load beats everything.
    always_comb begin
        toggle  = '0;
        state_d = state_q;
        tick_d  = 1'b0;
        if (!(state_q inside {IDLE, RUN, DONE})) begin
            state_d = IDLE;
        end
        if (Load) begin
            toggle  = count_q ^ LoadValue;
            state_d = (LoadValue != '0) ? RUN : IDLE;
        end else if (terminal) begin
            tick_d = 1'b1;
            if (AutoReload) begin
                toggle = count_q ^ reload_q;
            end else begin
                // count is 1 here, so toggling its set bits lands on 0
                toggle  = count_q;
                state_d = DONE;
            end
        end else if (run_en && (count_q > ONE)) begin
            // bit i toggles iff all lower bits are 0: exactly the bits that
            // differ between q and q-1 for any nonzero q
            toggle = count_q ^ (count_q - ONE);
        end
    end

    // State, reload and Tick registers.
    always_ff @(posedge Clock or negedge Clear_b) begin
        if (!Clear_b) begin
            state_q  <= IDLE;
            reload_q <= '0;
            tick_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            if (Load) begin
                reload_q <= LoadValue;
            end
        end
    end

    // Count storage, one T flip-flop per bit.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        tflipflop u_tff (
            .Clock   (Clock),
            .Enable  (toggle[i]),
            .Clear_b (Clear_b),
            .Q       (count_q[i])
        );
    end

    assign CounterValue = count_q;
    assign Tick         = tick_q;
    assign Busy         = (state_q == RUN);
    assign Done         = (state_q == DONE);

endmodule : down_counter_reload

// File: tb/tb_down_counter_reload.sv
module tb_down_counter_reload;

    logic       Clock;
    logic       Clear_b;
    logic       Enable;
    logic       Load;
    logic [7:0] LoadValue;
    logic       AutoReload;
    logic [7:0] CounterValue;
    logic       Tick;
    logic       Busy;
    logic       Done;

    logic       en4;
    logic       ld4;
    logic [3:0] lv4;
    logic       ar4;
    logic [3:0] cv4;
    logic       tick4;
    logic       busy4;
    logic       done4;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       ld;
        logic [7:0] lv;
        logic       en;
        logic       ar;
        logic [7:0] cv;
        logic       tick;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vecs[$];

    down_counter_reload #(.WIDTH(8)) u_dut (
        .Clock        (Clock),
        .Clear_b      (Clear_b),
        .Enable       (Enable),
        .Load         (Load),
        .LoadValue    (LoadValue),
        .AutoReload   (AutoReload),
        .CounterValue (CounterValue),
        .Tick         (Tick),
        .Busy         (Busy),
        .Done         (Done)
    );

    down_counter_reload #(.WIDTH(4)) u_dut4 (
        .Clock        (Clock),
        .Clear_b      (Clear_b),
        .Enable       (en4),
        .Load         (ld4),
        .LoadValue    (lv4),
        .AutoReload   (ar4),
        .CounterValue (cv4),
        .Tick         (tick4),
        .Busy         (busy4),
        .Done         (done4)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] cv, input logic t,
                             input logic b, input logic d);
        check({tag, " cv"},   32'(CounterValue), 32'(cv));
        check({tag, " tick"}, 32'(Tick),         32'(t));
        check({tag, " busy"}, 32'(Busy),         32'(b));
        check({tag, " done"}, 32'(Done),         32'(d));
    endtask

    function automatic void add(input logic ld, input logic [7:0] lv, input logic en,
                                input logic ar, input logic [7:0] cv, input logic t,
                                input logic b, input logic d);
        vec_t v;
        v.ld = ld; v.lv = lv; v.en = en; v.ar = ar;
        v.cv = cv; v.tick = t; v.busy = b; v.done = d;
        vecs.push_back(v);
    endfunction

    task automatic step(input logic ld, input logic [7:0] lv, input logic en, input logic ar);
        @(negedge Clock);
        Load = ld; LoadValue = lv; Enable = en; AutoReload = ar;
        @(posedge Clock);
        #1;
    endtask

    initial begin
        int k;
        Clear_b = 1'b0; Enable = 1'b0; Load = 1'b0; LoadValue = '0; AutoReload = 1'b0;
        en4 = 1'b0; ld4 = 1'b0; lv4 = '0; ar4 = 1'b0;

        // auto-reload period 4
        add(1, 4, 1, 1, 4, 0, 1, 0);
        add(0, 0, 1, 1, 3, 0, 1, 0);
        add(0, 0, 1, 1, 2, 0, 1, 0);
        add(0, 0, 1, 1, 1, 0, 1, 0);
        add(0, 0, 1, 1, 4, 1, 1, 0);
        add(0, 0, 1, 1, 3, 0, 1, 0);
        add(0, 0, 1, 1, 2, 0, 1, 0);
        add(0, 0, 1, 1, 1, 0, 1, 0);
        add(0, 0, 1, 1, 4, 1, 1, 0);
        add(0, 0, 1, 1, 3, 0, 1, 0);
        // one-shot 3, then hold in DONE, then reload 2
        add(1, 3, 1, 0, 3, 0, 1, 0);
        add(0, 0, 1, 0, 2, 0, 1, 0);
        add(0, 0, 1, 0, 1, 0, 1, 0);
        add(0, 0, 1, 0, 0, 1, 0, 1);
        add(0, 0, 1, 0, 0, 0, 0, 1);
        add(0, 0, 1, 1, 0, 0, 0, 1);
        add(1, 2, 1, 0, 2, 0, 1, 0);
        add(0, 0, 1, 0, 1, 0, 1, 0);
        add(0, 0, 1, 0, 0, 1, 0, 1);
        // period 6 with Enable alternating
        add(1, 6, 1, 1, 6, 0, 1, 0);
        add(0, 0, 1, 1, 5, 0, 1, 0);
        add(0, 0, 0, 1, 5, 0, 1, 0);
        add(0, 0, 1, 1, 4, 0, 1, 0);
        add(0, 0, 0, 1, 4, 0, 1, 0);
        add(0, 0, 1, 1, 3, 0, 1, 0);
        add(0, 0, 0, 1, 3, 0, 1, 0);
        add(0, 0, 1, 1, 2, 0, 1, 0);
        add(0, 0, 0, 1, 2, 0, 1, 0);
        add(0, 0, 1, 1, 1, 0, 1, 0);
        add(0, 0, 0, 1, 1, 0, 1, 0);
        add(0, 0, 1, 1, 6, 1, 1, 0);
        add(0, 0, 0, 1, 6, 0, 1, 0);
        // period 1 auto-reload: Tick continuous while enabled
        add(1, 1, 1, 1, 1, 0, 1, 0);
        add(0, 0, 1, 1, 1, 1, 1, 0);
        add(0, 0, 1, 1, 1, 1, 1, 0);
        add(0, 0, 1, 1, 1, 1, 1, 0);
        add(0, 0, 0, 1, 1, 0, 1, 0);
        // load 0 parks in IDLE
        add(1, 0, 1, 1, 0, 0, 0, 0);
        add(0, 0, 1, 1, 0, 0, 0, 0);
        // load beats a terminal edge
        add(1, 2, 1, 0, 2, 0, 1, 0);
        add(0, 0, 1, 0, 1, 0, 1, 0);
        add(1, 9, 1, 0, 9, 0, 1, 0);
        add(0, 0, 1, 0, 8, 0, 1, 0);

        #12;
        check_all("reset", 8'd0, 1'b0, 1'b0, 1'b0);
        check("reset cv4", 32'(cv4), 32'd0);
        @(negedge Clock);
        Clear_b = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].ar);
            check_all($sformatf("vec%0d", i), vecs[i].cv, vecs[i].tick, vecs[i].busy, vecs[i].done);
        end

        // asynchronous clear mid-count, then Enable alone does nothing
        step(1, 8, 1, 1);
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        check_all("pre-clear", 8'd5, 1'b0, 1'b1, 1'b0);
        #2;
        Clear_b = 1'b0;
        #1;
        check_all("async clear", 8'd0, 1'b0, 1'b0, 1'b0);
        @(negedge Clock);
        Clear_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 1);
            check_all($sformatf("post-clear%0d", i), 8'd0, 1'b0, 1'b0, 1'b0);
        end

        // clear while a Tick is showing
        step(1, 2, 1, 1);
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        check_all("tick before clear", 8'd2, 1'b1, 1'b1, 1'b0);
        #2;
        Clear_b = 1'b0;
        #1;
        check_all("clear on tick", 8'd0, 1'b0, 1'b0, 1'b0);
        @(negedge Clock);
        Clear_b = 1'b1;
        Enable = 1'b0;

        // 4-bit instance, full-scale period 15
        @(negedge Clock);
        ld4 = 1'b1; lv4 = 4'd15; en4 = 1'b1; ar4 = 1'b1;
        @(posedge Clock);
        #1;
        check("w4 load cv", 32'(cv4), 32'd15);
        check("w4 load busy", 32'(busy4), 32'd1);
        @(negedge Clock);
        ld4 = 1'b0;
        for (int n = 1; n <= 45; n++) begin
            @(posedge Clock);
            #1;
            k = n % 15;
            check($sformatf("w4 edge%0d cv", n), 32'(cv4), (k == 0) ? 32'd15 : 32'(15 - k));
            check($sformatf("w4 edge%0d tick", n), 32'(tick4), (k == 0) ? 32'd1 : 32'd0);
        end
        check("w4 done", 32'(done4), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule : tb_down_counter_reload
